// File: rtl/pipelined_add_sub_if.sv
// Operand/result bus for pipelined_add_sub: operand beat with valid/ready in, result beat with valid/ready out.
// Ports: in_valid/in_ready/a/b/cin/sub (operand side), out_valid/out_ready/sum/cout/ovf (result side).
// slave modport is the arithmetic unit; master modport is whoever feeds operands and drains results.
interface pipelined_add_sub_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, sum, cout, ovf
    );

    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, sum, cout, ovf
    );
endinterface

// File: rtl/pipelined_add_sub.sv
// Pipelined two's-complement add/sub: each stage ripples one WIDTH/STAGES slice and registers the carry.
// Latency STAGES cycles from accept to out_valid, +1 per stall cycle; one beat per cycle throughput.
// Backpressure: whole pipe advances only when the output slot is empty or drained; in_ready = advance.
//
// Ports: clk, rst_n (async, active-low); bus (slave) carries the operand beat
// (in_valid/in_ready, a, b, cin, sub) and the result beat (out_valid/out_ready, sum, cout, ovf).
module pipelined_add_sub #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    pipelined_add_sub_if.slave   bus
);
    localparam int SW  = WIDTH / STAGES;   // slice width
    localparam int MSB = WIDTH - 1;

    if ((WIDTH < 2) || (STAGES < 1) || ((WIDTH % STAGES) != 0)) begin : g_param_err
        $error("pipelined_add_sub: WIDTH must be >= 2 and a multiple of STAGES");
    end

    // Per-stage state. a/b ride along with the beat (b already conditioned for sub);
    // s holds the slices finished so far, c the carry into the next slice.
    logic [STAGES-1:0] vld_q, vld_d;
    logic [STAGES-1:0] c_q,   c_d;
    logic [WIDTH-1:0]  a_q [STAGES];
    logic [WIDTH-1:0]  a_d [STAGES];
    logic [WIDTH-1:0]  b_q [STAGES];
    logic [WIDTH-1:0]  b_d [STAGES];
    logic [WIDTH-1:0]  s_q [STAGES];
    logic [WIDTH-1:0]  s_d [STAGES];

    logic              adv;
    logic [WIDTH-1:0]  a_src;
    logic [WIDTH-1:0]  b_src;
    logic [WIDTH-1:0]  s_src;
    logic              c_src;
    logic              v_src;
    logic [SW:0]       slice_res;

    // The last stage is the output register, so the pipe may move whenever it is
    // empty or being consumed this cycle.
    always_comb begin
        adv       = !vld_q[STAGES-1] || bus.out_ready;
        vld_d     = vld_q;
        c_d       = c_q;
        a_d       = a_q;
        b_d       = b_q;
        s_d       = s_q;
        a_src     = '0;
        b_src     = '0;
        s_src     = '0;
        c_src     = 1'b0;
        v_src     = 1'b0;
        slice_res = '0;

        if (adv) begin
            for (int k = 0; k < STAGES; k++) begin
                if (k == 0) begin
                    // Subtract as A + ~B + 1; cin is meaningless for subtraction.
                    a_src = bus.a;
                    b_src = bus.sub ? ~bus.b : bus.b;
                    s_src = '0;
                    c_src = bus.sub ? 1'b1 : bus.cin;
                    v_src = bus.in_valid;
                end else begin
                    a_src = a_q[k-1];
                    b_src = b_q[k-1];
                    s_src = s_q[k-1];
                    c_src = c_q[k-1];
                    v_src = vld_q[k-1];
                end

                slice_res = {1'b0, a_src[k*SW +: SW]}
                          + {1'b0, b_src[k*SW +: SW]}
                          + {{SW{1'b0}}, c_src};

                vld_d[k]            = v_src;
                a_d[k]              = a_src;
                b_d[k]              = b_src;
                s_d[k]              = s_src;
                s_d[k][k*SW +: SW]  = slice_res[SW-1:0];
                c_d[k]              = slice_res[SW];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
            c_q   <= '0;
            for (int k = 0; k < STAGES; k++) begin
                a_q[k] <= '0;
                b_q[k] <= '0;
                s_q[k] <= '0;
            end
        end else begin
            vld_q <= vld_d;
            c_q   <= c_d;
            for (int k = 0; k < STAGES; k++) begin
                a_q[k] <= a_d[k];
                b_q[k] <= b_d[k];
                s_q[k] <= s_d[k];
            end
        end
    end

    // Outputs come straight from the last stage registers, so they hold on stall
    // and read all-zero in reset. Overflow uses the beat's own a and conditioned b.
    assign bus.in_ready  = adv;
    assign bus.out_valid = vld_q[STAGES-1];
    assign bus.sum       = s_q[STAGES-1];
    assign bus.cout      = c_q[STAGES-1];
    assign bus.ovf       = (a_q[STAGES-1][MSB] == b_q[STAGES-1][MSB]) &&
                           (s_q[STAGES-1][MSB] != a_q[STAGES-1][MSB]);
endmodule

// File: tb/tb_pipelined_add_sub.sv
// Bench for pipelined_add_sub (WIDTH=16, STAGES=4): directed corner beats, random streaming
// with random backpressure, and asynchronous reset mid-stream, checked against an arithmetic model.
// Inputs change on the falling edge; outputs are sampled 1ns later, away from the rising edge.
module tb_pipelined_add_sub;
    localparam int W = 16;

    logic clk;
    logic rst_n;

    pipelined_add_sub_if #(.WIDTH(W)) bus ();

    pipelined_add_sub #(.WIDTH(W), .STAGES(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
        int           stamp;
    } exp_t;

    exp_t         exp_q[$];
    int           total = 0;
    int           bad   = 0;
    int           cyc   = 0;
    int           n_acc = 0;
    logic         stall_prev = 1'b0;
    logic [W+2:0] stall_val;
    logic         got_flag;
    logic [W-1:0] last_sum;
    logic         last_cout;
    logic         last_ovf;
    int           last_lat;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference: plain integer arithmetic. Subtraction has "no borrow" carry when a >= b.
    function automatic exp_t ref_model(input logic [W-1:0] a, input logic [W-1:0] b,
                                       input logic cin, input logic sub);
        exp_t e;
        int   full;
        int   sa;
        int   sb;
        int   r;
        sa = $signed(a);
        sb = $signed(b);
        if (!sub) begin
            full   = int'(a) + int'(b) + int'(cin);
            r      = sa + sb + int'(cin);
            e.cout = (full > 65535);
        end else begin
            full   = int'(a) - int'(b);
            r      = sa - sb;
            e.cout = (a >= b);
        end
        e.sum   = full[W-1:0];
        e.ovf   = (r > 32767) || (r < -32768);
        e.stamp = 0;
        return e;
    endfunction

    // One clock of stimulus plus monitoring of the transfers the next rising edge will perform.
    task automatic cycle(input logic iv, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic ci, input logic su, input logic ordy);
        exp_t e;
        @(negedge clk);
        bus.in_valid  = iv;
        bus.a         = a;
        bus.b         = b;
        bus.cin       = ci;
        bus.sub       = su;
        bus.out_ready = ordy;
        #1;
        if (stall_prev)
            chk("hold_stable", 32'({bus.out_valid, bus.sum, bus.cout, bus.ovf}), 32'(stall_val));
        stall_prev = 1'b0;
        if (bus.out_valid && !bus.out_ready) begin
            chk("stall_in_ready", 32'(bus.in_ready), 32'd0);
            stall_prev = 1'b1;
            stall_val  = {bus.out_valid, bus.sum, bus.cout, bus.ovf};
        end
        if (bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
                chk("spurious_out", 32'(bus.out_valid), 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("result", 32'({bus.sum, bus.cout, bus.ovf}), 32'({e.sum, e.cout, e.ovf}));
                got_flag  = 1'b1;
                last_sum  = bus.sum;
                last_cout = bus.cout;
                last_ovf  = bus.ovf;
                last_lat  = cyc - e.stamp;
            end
        end
        if (bus.in_valid && bus.in_ready) begin
            e       = ref_model(a, b, ci, su);
            e.stamp = cyc;
            exp_q.push_back(e);
            n_acc++;
        end
        cyc++;
    endtask

    // Single beat into an empty pipe; checks the spec's literal result and the 4-cycle latency.
    task automatic directed(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic ci, input logic su, input logic [W-1:0] xs,
                            input logic xc, input logic xo);
        got_flag = 1'b0;
        cycle(1'b1, a, b, ci, su, 1'b1);
        for (int i = 0; i < 10 && !got_flag; i++)
            cycle(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
        chk({tag, "_seen"}, 32'(got_flag), 32'd1);
        if (got_flag) begin
            chk({tag, "_sum"},  32'(last_sum),  32'(xs));
            chk({tag, "_cout"}, 32'(last_cout), 32'(xc));
            chk({tag, "_ovf"},  32'(last_ovf),  32'(xo));
            chk({tag, "_lat"},  32'(last_lat),  32'd4);
        end
    endtask

    initial begin
        int guard;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.cin       = 1'b0;
        bus.sub       = 1'b0;
        bus.out_ready = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_sum",       32'(bus.sum),       32'd0);
        chk("rst_cout",      32'(bus.cout),      32'd0);
        chk("rst_ovf",       32'(bus.ovf),       32'd0);
        chk("rst_in_ready",  32'(bus.in_ready),  32'd1);
        rst_n = 1'b1;

        // Directed corners.
        directed("t1_wrap",  16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        directed("t2_ovf",   16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
        directed("t3_cin",   16'h0FFF, 16'h0000, 1'b1, 1'b0, 16'h1000, 1'b0, 1'b0);
        directed("t4_sub",   16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0);
        directed("t4_subov", 16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);

        // Fill the pipe with the output blocked, then stream randomly with random backpressure.
        for (int i = 0; i < 6; i++)
            cycle(1'b1, 16'($urandom_range(0, 65535)), 16'($urandom_range(0, 65535)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
        guard = 0;
        while (n_acc < 30 && guard < 500) begin
            cycle(1'($urandom_range(0, 3) != 0), 16'($urandom_range(0, 65535)),
                  16'($urandom_range(0, 65535)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            guard++;
        end
        chk("stream_budget", 32'(guard < 500), 32'd1);
        guard = 0;
        while (exp_q.size() > 0 && guard < 50) begin
            cycle(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
            guard++;
        end
        chk("drain_empty", 32'(exp_q.size()), 32'd0);

        // Reset with three beats in flight.
        for (int i = 0; i < 3; i++)
            cycle(1'b1, 16'($urandom_range(0, 65535)), 16'($urandom_range(0, 65535)),
                  1'b0, 1'b0, 1'b1);
        bus.in_valid = 1'b0;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("arst_sum",       32'(bus.sum),       32'd0);
        chk("arst_in_ready",  32'(bus.in_ready),  32'd1);
        exp_q.delete();
        stall_prev = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++)
            cycle(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
        directed("t6_after", 16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
